// File: rtl/vga_timing_pkg.sv
// Shared timing constants, coordinate type and window helper for the 640x480@60
// display timing generator.
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    localparam logic SYNC_ACTIVE_DEF = 1'b0;

    // Half-open window test done in int so an end bound of 1024 still works.
    function automatic logic in_window(input int c, input int lo, input int hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up-counter with enable; exposes the next value so callers can
// register decodes that line up with the count itself.
module mod_counter #(
    parameter int WIDTH   = 10,
    parameter int MODULUS = 800,
    parameter int RST_VAL = MODULUS - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_nxt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RSTV  = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;

    always_comb begin
        wrap_d  = en && (count_q == LAST);
        count_d = count_q;
        if (wrap_d) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RSTV;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign count_nxt = count_d;
    assign wrap      = wrap_d;

endmodule

// File: rtl/vga_sync.sv
// Display timing generator: two cascaded modulo counters plus registered
// sync/blank decode and line/frame start pulses, all advanced by pix_en.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE   = H_VISIBLE_DEF,
    parameter int   H_FP        = H_FP_DEF,
    parameter int   H_SYNC      = H_SYNC_DEF,
    parameter int   H_BP        = H_BP_DEF,
    parameter int   V_VISIBLE   = V_VISIBLE_DEF,
    parameter int   V_FP        = V_FP_DEF,
    parameter int   V_SYNC      = V_SYNC_DEF,
    parameter int   V_BP        = V_BP_DEF,
    parameter logic SYNC_ACTIVE = SYNC_ACTIVE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int HS_LO = H_VISIBLE + H_FP;
    localparam int HS_HI = H_VISIBLE + H_FP + H_SYNC;
    localparam int VS_LO = V_VISIBLE + V_FP;
    localparam int VS_HI = V_VISIBLE + V_FP + V_SYNC;

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_timing
        $error("vga_sync: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    coord_t h_cnt, h_nxt, v_cnt, v_nxt;
    logic   h_wrap, v_wrap;

    mod_counter #(
        .WIDTH   (COORD_W),
        .MODULUS (H_TOTAL),
        .RST_VAL (H_TOTAL - 1)
    ) u_h_cnt (
        .clk       (clk),
        .rst       (rst),
        .en        (pix_en),
        .count     (h_cnt),
        .count_nxt (h_nxt),
        .wrap      (h_wrap)
    );

    mod_counter #(
        .WIDTH   (COORD_W),
        .MODULUS (V_TOTAL),
        .RST_VAL (V_TOTAL - 1)
    ) u_v_cnt (
        .clk       (clk),
        .rst       (rst),
        .en        (h_wrap),
        .count     (v_cnt),
        .count_nxt (v_nxt),
        .wrap      (v_wrap)
    );

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic video_on_q, video_on_d;
    logic line_start_q, frame_start_q;

    // Decode the counters' next values so sync, blank and coordinates change together.
    always_comb begin
        hsync_d    = in_window(int'(h_nxt), HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d    = in_window(int'(v_nxt), VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        video_on_d = (int'(h_nxt) < H_VISIBLE) && (int'(v_nxt) < V_VISIBLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = h_cnt;
    assign pixel_y     = v_cnt;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: default 640x480 instance plus a tiny-geometry instance
// with inverted sync polarity, both compared against a strobe-count model.
module tb_vga_sync;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic pix_en;

    always #5 clk = ~clk;

    logic         a_hs, a_vs, a_von, a_ls, a_fs;
    logic [9:0]   a_x, a_y;
    logic         b_hs, b_vs, b_von, b_ls, b_fs;
    logic [9:0]   b_x, b_y;

    vga_sync u_dut_a (
        .clk (clk), .rst (rst), .pix_en (pix_en),
        .hsync (a_hs), .vsync (a_vs), .video_on (a_von),
        .pixel_x (a_x), .pixel_y (a_y),
        .line_start (a_ls), .frame_start (a_fs)
    );

    vga_sync #(
        .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_VISIBLE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .SYNC_ACTIVE (1'b1)
    ) u_dut_b (
        .clk (clk), .rst (rst), .pix_en (pix_en),
        .hsync (b_hs), .vsync (b_vs), .video_on (b_von),
        .pixel_x (b_x), .pixel_y (b_y),
        .line_start (b_ls), .frame_start (b_fs)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Strobes accepted since the last reset, and whether the latest edge took one.
    longint k = 0;
    bit     s = 1'b0;

    // Position is the strobe count modulo the frame size, unfolded into x/y.
    function automatic logic [24:0] model(input int hv, input int hf, input int hsw, input int hb,
                                          input int vv, input int vf, input int vsw, input int vb,
                                          input bit act, input longint kk, input bit ss);
        int     ht, vt, x, y;
        longint p;
        logic   hs, vs, von, ls, fs;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (kk == 0) begin
            p = -1;
            x = ht - 1;
            y = vt - 1;
        end else begin
            p = (kk - 1) % (ht * vt);
            x = int'(p % ht);
            y = int'(p / ht);
        end
        hs  = (x >= hv + hf && x < hv + hf + hsw) ? act : ~act;
        vs  = (y >= vv + vf && y < vv + vf + vsw) ? act : ~act;
        von = (x < hv) && (y < vv);
        ls  = ss && (x == 0);
        fs  = ss && (p == 0);
        return {hs, vs, von, 10'(x), 10'(y), ls, fs};
    endfunction

    task automatic compare_all(input string tag);
        check_eq({tag, "_a"}, 32'({a_hs, a_vs, a_von, a_x, a_y, a_ls, a_fs}),
                 32'(model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, k, s)));
        check_eq({tag, "_b"}, 32'({b_hs, b_vs, b_von, b_x, b_y, b_ls, b_fs}),
                 32'(model(8, 2, 3, 2, 6, 1, 2, 2, 1'b1, k, s)));
    endtask

    task automatic step(input logic en, input string tag);
        pix_en = en;
        @(posedge clk);
        if (rst) begin
            s = 1'b0;
        end else begin
            s = en;
            if (en) k++;
        end
        #1;
        compare_all(tag);
    endtask

    int last_fs;
    int pairs;

    initial begin
        rst    = 1'b1;
        pix_en = 1'b0;
        #2;
        compare_all("reset_async");
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), "reset_hold");
        rst = 1'b0;
        step(1'b1, "first_strobe");
        check_eq("first_fs", 32'(a_fs), 32'd1);
        step(1'b0, "fs_drop");

        for (int c = 0; c < 1000; c++) step(c % 4 == 0, "div4");
        for (int c = 0; c < 3000; c++) step(1'($urandom_range(0, 1)), "rand");
        for (int c = 0; c < 10; c++) step(1'b0, "freeze");

        last_fs = -1;
        pairs   = 0;
        for (int c = 0; c < 2000; c++) begin
            step(1'b1, "cont");
            if (b_fs) begin
                if (last_fs >= 0) begin
                    check_eq("fs_gap_cont", 32'(c - last_fs), 32'd165);
                    pairs++;
                end
                last_fs = c;
            end
        end
        check_eq("fs_pairs_cont", 32'(pairs >= 2), 32'd1);

        last_fs = -1;
        pairs   = 0;
        for (int c = 0; c < 2700; c++) begin
            step(c % 4 == 0, "div4_frame");
            if (b_fs) begin
                if (last_fs >= 0) begin
                    check_eq("fs_gap_div4", 32'(c - last_fs), 32'd660);
                    pairs++;
                end
                last_fs = c;
            end
        end
        check_eq("fs_pairs_div4", 32'(pairs >= 2), 32'd1);

        for (int c = 0; c < 37; c++) step(1'b1, "pre_reset");
        #2 rst = 1'b1;
        k = 0;
        s = 1'b0;
        #1;
        compare_all("midframe_async");
        step(1'b1, "midframe_hold");
        rst = 1'b0;
        step(1'b1, "restart");
        check_eq("restart_fs", 32'(a_fs), 32'd1);
        for (int c = 0; c < 500; c++) step(1'($urandom_range(0, 1)), "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
# vga_sync

Display timing generator for 640x480 at 60 Hz. Consumes the one-in-four pixel-enable strobe produced by the 25 MHz enable divider on the 100 MHz system clock. Produces horizontal and vertical sync, the active-video flag, and the current pixel coordinates for the downstream pixel/colour generator. All logic runs in the system clock domain; the pixel rate comes from gating with `pix_en`.

## Interface
Parameters (defaults match 640x480@60):
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch, in pixels
- `H_SYNC`, 96, horizontal sync width, in pixels
- `H_BP`, 48, horizontal back porch, in pixels
- `V_VISIBLE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch, in lines
- `V_SYNC`, 2, vertical sync width, in lines
- `V_BP`, 33, vertical back porch, in lines
- `SYNC_ACTIVE`, 1'b0, asserted level of `hsync` and `vsync`

Ports:
- `clk`  in  1  system clock, 100 MHz
- `rst`  in  1  asynchronous, active-high reset
- `pix_en`  in  1  pixel strobe, one clk wide; the counters advance only on cycles where it is high
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `video_on`  out  1  high while the current pixel lies in the visible area
- `pixel_x`  out  10  horizontal count, 0..H_TOTAL-1
- `pixel_y`  out  10  vertical count, 0..V_TOTAL-1
- `line_start`  out  1  one-clk pulse when `pixel_x` wraps to 0
- `frame_start`  out  1  one-clk pulse when the counters wrap to (0,0)

## Operation
- Derived constants:
  - H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP (default 800).
  - V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP (default 525).
  - Both totals must be ≤ 1024; elaboration fails otherwise.
- Horizontal counter `h`:
  - Increments on each clk edge with `pix_en`=1.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter `v`:
  - Increments only on the `h` wrap.
  - At V_TOTAL-1 it wraps to 0 on that same edge.
- Decode, applied to the new counter values:
  - `hsync` = SYNC_ACTIVE when H_VISIBLE+H_FP ≤ h < H_VISIBLE+H_FP+H_SYNC (656..751); otherwise ~SYNC_ACTIVE.
  - `vsync` = SYNC_ACTIVE when V_VISIBLE+V_FP ≤ v < V_VISIBLE+V_FP+V_SYNC (490..491); otherwise ~SYNC_ACTIVE.
  - `video_on` = (h < H_VISIBLE) && (v < V_VISIBLE).
  - `pixel_x` = h and `pixel_y` = v.
- `line_start` is high for exactly the clk cycle following an edge on which h wrapped.
- `frame_start` is high for that same cycle when v also wrapped. It never lasts more than one clk, even if `pix_en` stays high.
- When `pix_en` is 0, every output except the pulses holds its value; both pulses are 0.
- Reset (asynchronous, immediate):
  - h = H_TOTAL-1 (799), v = V_TOTAL-1 (524).
  - `hsync` = `vsync` = ~SYNC_ACTIVE, `video_on` = 0.
  - `line_start` = `frame_start` = 0.
  - The first `pix_en` after reset is released therefore wraps to (0,0) and raises `frame_start`.
- Reset asserted mid-frame abandons the frame. There is no partial-frame recovery.

## Timing
- All outputs are flops on `clk`; there is no combinational path from inputs to outputs.
- Latency: outputs reflect the new position on the same edge that samples `pix_en`=1, i.e. one clk after the strobe is presented.
- `pix_en` held high continuously is legal: the counters advance on every clk.
- `pix_en` presented while `rst` is high is ignored.
- Default frame = 800 × 525 = 420000 strobes = 1,680,000 clk at one strobe per 4 clk.
- `hsync` is asserted for 96 strobes per line; `vsync` is asserted for 1600 strobes per frame.
- Sync edges, the `video_on` transition and the counter update for a given pixel all occur on the same edge, so no skew exists between them.

## Structure
- Package `vga_timing_pkg` holds:
  - the default timing constants above;
  - the derived H_TOTAL/V_TOTAL;
  - the 10-bit coordinate type;
  - the sync-polarity constant.
- Sub-module `mod_counter` (width, modulus, reset value; inputs `en`; outputs count and `wrap`), instantiated twice:
  - horizontal, with `en` = `pix_en`;
  - vertical, with `en` = horizontal `wrap`.
- The top level holds only the decode flops and the pulse generation.

## Test plan
- Reset:
  - While `rst`=1: `hsync`=1, `vsync`=1, `video_on`=0, `pixel_x`=799, `pixel_y`=524, pulses 0.
  - First `pix_en` after release: (0,0), `video_on`=1, `frame_start`=1 for exactly one clk.
- Horizontal line:
  - `hsync` falls when `pixel_x`=656 and rises at 752.
  - `video_on` falls at `pixel_x`=640.
  - At 799→0, `line_start`=1 and `pixel_y` increments.
- Vertical frame:
  - `vsync`=0 only for `pixel_y` 490..491.
  - `video_on`=0 for all of lines 480..524.
  - Consecutive `frame_start` pulses are exactly 420000 strobes apart.
- Strobe gating:
  - With `pix_en` from a 1-in-4 divider, consecutive `frame_start` pulses are 1,680,000 clk apart.
  - With `pix_en` held 0 for 10 clk, all outputs are frozen and the pulses stay 0.
- Continuous `pix_en`=1: the counters advance every clk, and `frame_start` stays one clk wide at each wrap.
- Mid-frame reset at (300,200):
  - Reset values appear asynchronously, before the next clk edge.
  - After release, the first strobe restarts at (0,0) with `frame_start`=1.
